mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multicycle main controller for the MIPS core. It sequences one shared ALU, register file and unified memory port across the fetch, decode, execute, memory and writeback steps.
- Drives the 6-bit aluop consumed by alucontrol. I-type ALU ops pass the opcode through; R-type uses a reserved code that makes alucontrol decode funct.
- Stalls on a memory ready handshake.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
ALUOP_RTYPE, 6'b111111, aluop value that makes alucontrol fall through to funct decode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  6  opcode from instruction register, stable from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
iord  out  1  0 = PC address, 1 = ALUOut address
irwrite  out  1  load instruction register
pcen  out  1  PC write enable (includes branch condition)
pcsrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
alusrca  out  1  0 = PC, 1 = rs
alusrcb  out  2  00 rt, 01 constant 4, 10 extended imm, 11 imm<<2
extop  out  1  1 = sign-extend, 0 = zero-extend imm
aluop  out  6  to alucontrol
regdst  out  1  0 = rt, 1 = rd
memtoreg  out  1  writeback source is memory data
regwrite  out  1  register file write enable
illegal_op  out  1  one-cycle pulse on unsupported opcode
state  out  4  current state, debug
retired  out  CNT_W  retired-instruction count, wraps

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- While reset is high:
  - state = FETCH and retired = 0.
  - All strobes are forced to 0: memread, memwrite, irwrite, pcen, regwrite, illegal_op.
- After reset deasserts, FETCH begins on the next edge.
- Reset mid-instruction aborts it with no partial register or memory write beyond the cycle in progress.
- Moore outputs are decoded from state (plus zero and mem_ready where noted). Every output not listed for a state is 0; aluop defaults to 000000.
- States and per-state outputs:
  - FETCH (0): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=000000, pcsrc=00. When mem_ready=1: irwrite=1, pcen=1, next DECODE. Otherwise hold all outputs and stay.
  - DECODE (1): alusrca=0, alusrcb=11, extop=1, aluop=000000. Next state by op:
    - lw/sw -> MEMADR
    - 000000 -> RTYPEEX
    - beq 000100 -> BEQEX
    - j 000010 -> JEX
    - addi/addiu/slti/andi/ori/xori/lui -> IMMEX
    - any other opcode -> illegal_op=1 this cycle, next FETCH, no retire
  - MEMADR (2): alusrca=1, alusrcb=10, extop=1, aluop=000000. Next MEMRD if op=100011, MEMWR if op=101011.
  - MEMRD (3): memread=1, iord=1. Stay until mem_ready, then MEMWB.
  - MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Next FETCH, retire.
  - MEMWR (5): memwrite=1, iord=1, held until mem_ready. Then next FETCH, retire.
  - RTYPEEX (6): alusrca=1, alusrcb=00, aluop=ALUOP_RTYPE. Next RTYPEWB.
  - RTYPEWB (7): regdst=1, regwrite=1. Next FETCH, retire.
  - BEQEX (8): alusrca=1, alusrcb=00, aluop=000001, pcsrc=01, pcen=zero. Next FETCH, retire regardless of branch outcome.
  - IMMEX (9): alusrca=1, alusrcb=10, aluop=op. extop=0 for andi/ori/xori, else 1. Next IMMWB.
  - IMMWB (10): regdst=0, regwrite=1. Next FETCH, retire.
  - JEX (11): pcsrc=10, pcen=1. Next FETCH, retire.
  - Unused encodings 12-15: next FETCH, outputs idle.
- Retire: retired increments by 1 on the clock edge leaving a retiring state. It wraps from all-ones to 0.
- Latency with mem_ready tied high:
  - lw 5 cycles
  - sw, R-type, I-type 4 cycles
  - beq, j 3 cycles
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings S_FETCH through S_JEX
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI
  - aluop constants ALUOP_ADD=000000, ALUOP_SUB=000001, ALUOP_RTYPE
- One combinational sub-module, mips_ctrl_outdec, maps (state, op, zero, mem_ready) to the output bundle.
- State register, next-state logic and retire counter stay in mips_mc_ctrl.

Test Plan:
- Reset: assert reset mid-MEMWR with memwrite=1 -> memwrite drops to 0 immediately (asynchronous), state=0, retired=0.
- lw, op=100011, mem_ready=1: states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. retired goes 0->1.
- sw, op=101011, mem_ready low for 3 cycles in MEMWR: memwrite held 4 cycles, then FETCH. No regwrite at any point. retired +1.
- beq, op=000100: with zero=1, pcen=1 and pcsrc=01 in BEQEX. With zero=0, pcen=0 in BEQEX. Both cases take 3 cycles and retire.
- I/R ops: ori 001101 -> aluop=001101 and extop=0 in IMMEX. addi 001000 -> extop=1. R-type 000000 -> aluop=111111 and regdst=1 in RTYPEWB.
- Illegal op=111000: illegal_op pulses for 1 cycle in DECODE, next state FETCH, retired unchanged. Preset retired=all-ones, then run j -> retired wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: FSM states,
// opcodes, aluop codes and the control bundle driven to the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] ALUOP_ADD   = 6'b000000;
  localparam logic [5:0] ALUOP_SUB   = 6'b000001;
  localparam logic [5:0] ALUOP_RTYPE = 6'b111111;

  // Everything the controller drives to the datapath in one cycle.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [5:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;
  } ctrl_t;

  // I-type ALU instructions handled by the IMMEX/IMMWB path.
  function automatic logic is_imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Logical immediates take a zero-extended operand.
  function automatic logic is_logic_imm_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return is_imm_alu_op(op) || (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Output decoder: maps the current state (plus op, zero and mem_ready where
// a state needs them) to the datapath control bundle. Purely combinational.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter logic [5:0] ALUOP_R = 6'b111111
) (
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control values; anything a state does not mention stays 0.
  always_comb begin
    // NOTE: assigning the whole bundle a default first keeps every path
    // fully specified, so no latch is inferred for fields a state skips.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
        if (mem_ready) begin
          ctrl.irwrite = 1'b1;
          ctrl.pcen    = 1'b1;
        end
      end
      S_DECODE: begin
        ctrl.alusrcb    = 2'b11;
        ctrl.extop      = 1'b1;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.illegal_op = !is_legal_op(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.extop   = 1'b1;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b00;
        ctrl.aluop   = ALUOP_R;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b00;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.pcen    = zero;
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = op;
        ctrl.extop   = !is_logic_imm_op(op);
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JEX: begin
        ctrl.pcsrc = 2'b10;
        ctrl.pcen  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic and
// retired-instruction counter. Output decoding lives in mips_ctrl_outdec.
module mips_mc_ctrl #(
  parameter int         CNT_W       = 32,
  parameter logic [5:0] ALUOP_RTYPE = mips_ctrl_pkg::ALUOP_RTYPE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic [1:0]       pcsrc,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             extop,
  output logic [5:0]       aluop,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  import mips_ctrl_pkg::*;

  state_t           state_q, state_d;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  mips_ctrl_outdec #(.ALUOP_R(ALUOP_RTYPE)) u_outdec (
    .state     (state_q),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Next state and the retire strobe marking the last cycle of an instruction.
  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = is_imm_alu_op(op) ? S_IMMEX : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   retire  = 1'b1;
      S_MEMWR: begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: retire  = 1'b1;
      S_BEQEX:   retire  = 1'b1;
      S_IMMEX:   state_d = S_IMMWB;
      S_IMMWB:   retire  = 1'b1;
      S_JEX:     retire  = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  // Strobes are masked while reset is high so nothing fires during reset.
  assign memread    = ctrl.memread    & ~reset;
  assign memwrite   = ctrl.memwrite   & ~reset;
  assign irwrite    = ctrl.irwrite    & ~reset;
  assign pcen       = ctrl.pcen       & ~reset;
  assign regwrite   = ctrl.regwrite   & ~reset;
  assign illegal_op = ctrl.illegal_op & ~reset;
  assign iord       = ctrl.iord;
  assign pcsrc      = ctrl.pcsrc;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign extop      = ctrl.extop;
  assign aluop      = ctrl.aluop;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. Each instruction is turned into an
// expected per-cycle trace (step list from the instruction's class, stall
// counts and branch outcome); the DUT is driven from the trace and checked
// every cycle. A small counter width makes wrap-around reachable.
module tb_mips_mc_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] L_RTYPE = 6'b000000, L_LW = 6'b100011, L_SW = 6'b101011,
                         L_BEQ = 6'b000100, L_J = 6'b000010, L_ADDI = 6'b001000,
                         L_ADDIU = 6'b001001, L_SLTI = 6'b001010, L_ANDI = 6'b001100,
                         L_ORI = 6'b001101, L_XORI = 6'b001110, L_LUI = 6'b001111;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op;
  logic             zero, mem_ready;
  logic             memread, memwrite, iord, irwrite, pcen, alusrca, extop;
  logic             regdst, memtoreg, regwrite, illegal_op;
  logic [1:0]       pcsrc, alusrcb;
  logic [5:0]       aluop;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] exp_retired;

  mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .extop(extop), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       mr, z, ret;
    logic       memread, memwrite, iord, irwrite, pcen, alusrca, extop;
    logic       regdst, memtoreg, regwrite, illegal;
    logic [1:0] pcsrc, alusrcb;
    logic [5:0] aluop;
  } step_t;

  step_t trace[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [5:0] o);
    return o inside {L_RTYPE, L_LW, L_SW, L_BEQ, L_J, L_ADDI, L_ADDIU, L_SLTI,
                     L_ANDI, L_ORI, L_XORI, L_LUI};
  endfunction

  // A step with every output idle; mem_ready and zero random unless set later.
  function automatic step_t idle(input logic [3:0] st);
    step_t s;
    s = '{st: st, mr: 1'($urandom), z: 1'($urandom), default: '0};
    return s;
  endfunction

  // Expand one instruction into its expected cycle-by-cycle behaviour.
  task automatic build(input logic [5:0] o, input int fstall, input int mstall,
                       input logic z);
    step_t s;
    trace.delete();
    for (int i = 0; i <= fstall; i++) begin
      s = idle(0); s.memread = 1; s.alusrcb = 2'b01;
      s.mr = (i == fstall); s.irwrite = s.mr; s.pcen = s.mr;
      trace.push_back(s);
    end
    s = idle(1); s.alusrcb = 2'b11; s.extop = 1; s.illegal = !legal(o);
    trace.push_back(s);
    if (o == L_LW || o == L_SW) begin
      s = idle(2); s.alusrca = 1; s.alusrcb = 2'b10; s.extop = 1;
      trace.push_back(s);
      for (int i = 0; i <= mstall; i++) begin
        s = idle(o == L_LW ? 4'd3 : 4'd5); s.iord = 1;
        if (o == L_LW) s.memread = 1; else s.memwrite = 1;
        s.mr = (i == mstall); s.ret = (o == L_SW) && s.mr;
        trace.push_back(s);
      end
      if (o == L_LW) begin
        s = idle(4); s.memtoreg = 1; s.regwrite = 1; s.ret = 1;
        trace.push_back(s);
      end
    end else if (o == L_RTYPE) begin
      s = idle(6); s.alusrca = 1; s.aluop = 6'b111111; trace.push_back(s);
      s = idle(7); s.regdst = 1; s.regwrite = 1; s.ret = 1; trace.push_back(s);
    end else if (o == L_BEQ) begin
      s = idle(8); s.alusrca = 1; s.aluop = 6'b000001; s.pcsrc = 2'b01;
      s.z = z; s.pcen = z; s.ret = 1; trace.push_back(s);
    end else if (o == L_J) begin
      s = idle(11); s.pcsrc = 2'b10; s.pcen = 1; s.ret = 1; trace.push_back(s);
    end else if (legal(o)) begin
      s = idle(9); s.alusrca = 1; s.alusrcb = 2'b10; s.aluop = o;
      s.extop = !(o inside {L_ANDI, L_ORI, L_XORI}); trace.push_back(s);
      s = idle(10); s.regwrite = 1; s.ret = 1; trace.push_back(s);
    end
  endtask

  // Drive one instruction: inputs just after the rising edge, checks at the
  // falling edge. Assumes the DUT sits in FETCH on entry.
  task automatic run_instr(input logic [5:0] o, input int fstall, input int mstall,
                           input logic z);
    build(o, fstall, mstall, z);
    op = o;
    foreach (trace[i]) begin
      mem_ready = trace[i].mr;
      zero      = trace[i].z;
      @(negedge clk);
      check($sformatf("state op=%0h", o), 32'(state), 32'(trace[i].st));
      check($sformatf("strobes s%0d", trace[i].st),
            32'({memread, memwrite, irwrite, pcen, regwrite, illegal_op}),
            32'({trace[i].memread, trace[i].memwrite, trace[i].irwrite,
                 trace[i].pcen, trace[i].regwrite, trace[i].illegal}));
      check($sformatf("datapath s%0d", trace[i].st),
            32'({iord, pcsrc, alusrca, alusrcb, extop, regdst, memtoreg}),
            32'({trace[i].iord, trace[i].pcsrc, trace[i].alusrca, trace[i].alusrcb,
                 trace[i].extop, trace[i].regdst, trace[i].memtoreg}));
      check($sformatf("aluop s%0d", trace[i].st), 32'(aluop), 32'(trace[i].aluop));
      check("retired", 32'(retired), 32'(exp_retired));
      @(posedge clk);
      #1;
      if (trace[i].ret) exp_retired = exp_retired + 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_retired = '0;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [12] = '{L_RTYPE, L_LW, L_SW, L_BEQ, L_J, L_ADDI, L_ADDIU,
                             L_SLTI, L_ANDI, L_ORI, L_XORI, L_LUI};
    logic [5:0] o;
    if ($urandom_range(0, 9) == 0) begin
      do o = 6'($urandom); while (legal(o));
      return o;
    end
    return ops[$urandom_range(0, 11)];
  endfunction

  initial begin
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    exp_retired = '0;
    #2;
    check("reset state", 32'(state), 32'd0);
    check("reset retired", 32'(retired), 32'd0);
    check("reset strobes", 32'({memread, memwrite, irwrite, pcen, regwrite, illegal_op}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed instructions.
    run_instr(L_LW, 0, 0, 1'b0);
    check("lw retire", 32'(retired), 32'd1);
    run_instr(L_SW, 0, 3, 1'b0);
    run_instr(L_BEQ, 0, 0, 1'b1);
    run_instr(L_BEQ, 0, 0, 1'b0);
    run_instr(6'b001101, 0, 0, 1'b0);
    run_instr(L_ADDI, 0, 0, 1'b0);
    run_instr(L_RTYPE, 0, 0, 1'b0);
    run_instr(6'b111000, 0, 0, 1'b0);
    run_instr(L_LW, 2, 2, 1'b0);

    // Randomized instruction stream with random stalls.
    for (int n = 0; n < 200; n++)
      run_instr(rand_op(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, 1'($urandom));

    // Reset asserted mid-MEMWR must drop memwrite at once and clear state.
    op = L_SW; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw in MEMWR", 32'(state), 32'd5);
    check("memwrite before reset", 32'(memwrite), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("memwrite async drop", 32'(memwrite), 32'd0);
    check("state async reset", 32'(state), 32'd0);
    check("retired async reset", 32'(retired), 32'd0);
    check("memread during reset", 32'(memread), 32'd0);
    do_reset();

    // Counter wrap: retire until all-ones, then a jump wraps it to zero.
    while (exp_retired != '1)
      run_instr(($urandom_range(0, 1) == 0) ? L_J : L_RTYPE, 0, 0, 1'b0);
    check("retired all-ones", 32'(retired), 32'(4'hF));
    run_instr(L_J, 0, 0, 1'b0);
    check("retired wrap", 32'(retired), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
